// File: rtl/adc_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : adc_scan_pkg                                          |
// | Desc     : Shared widths and scan FSM state encoding for the     |
// |            ADC channel scan controller.                          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package adc_scan_pkg;

  localparam int ADC_W = 12;
  localparam int CH_W  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEEK    = 3'd1,
    DISCARD = 3'd2,
    ACCUM   = 3'd3,
    STORE   = 3'd4
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_ch_next.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : adc_ch_next                                           |
// | Desc     : Find-first-set over a channel mask, restricted to     |
// |            indices above cur unless first is high.               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module adc_ch_next
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   nxt_idx,
  output logic              found
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (CH_W'(i) > cur))) begin
        nxt_idx = CH_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : adc_scan_ctrl                                         |
// | Desc     : Sequences the ADC channel select over a mask, drops   |
// |            stale conversions after each change, averages         |
// |            2^AVG_LOG2 samples and stores one result per channel. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int AVG_LOG2  = 2,
  parameter int DISCARD_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_result,
  output logic [CH_W-1:0]   chan,
  output logic              busy,
  output logic              scan_done,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ADC_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] res_valid
);

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int SMP_W  = AVG_LOG2 + 1;
  localparam int DISC_W = 2;
  localparam int BANK_N = 1 << CH_W;

  scan_state_t       state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADC_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_CH-1:0] res_valid_q, res_valid_d;
  // Bank is sized to the full select range so any rd_ch/cur index is legal;
  // entries at or above NUM_CH are never written and stay zero.
  logic [ADC_W-1:0]  bank_q [BANK_N];
  logic [ADC_W-1:0]  bank_d [BANK_N];

  logic [CH_W-1:0]   first_idx, next_idx;
  logic              first_found, next_found;
  logic [ADC_W-1:0]  store_val;
  logic              rd_in_range;

  // Lowest enabled channel of the live mask, used when a pass begins.
  adc_ch_next #(.NUM_CH(NUM_CH)) u_first (
    .mask    (ch_mask),
    .cur     ('0),
    .first   (1'b1),
    .nxt_idx (first_idx),
    .found   (first_found)
  );

  // Next enabled channel above cur within the mask latched for this pass.
  adc_ch_next #(.NUM_CH(NUM_CH)) u_next (
    .mask    (mask_q),
    .cur     (cur_q),
    .first   (1'b0),
    .nxt_idx (next_idx),
    .found   (next_found)
  );

  assign store_val   = ADC_W'(acc_q >> AVG_LOG2);
  assign rd_in_range = ({1'b0, rd_ch} < (CH_W + 1)'(NUM_CH));

  // Scan sequencing, averaging, result bank and read port next-state logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cur_d       = cur_q;
    chan_d      = chan_q;
    busy_d      = busy_q;
    scan_done_d = 1'b0;
    disc_d      = disc_q;
    smp_d       = smp_q;
    acc_d       = acc_q;
    bank_d      = bank_q;
    res_valid_d = res_valid_q;
    rd_data_d   = rd_in_range ? bank_q[rd_ch] : '0;

    case (state_q)
      IDLE: begin
        if ((start || cont) && first_found) begin
          mask_d  = ch_mask;
          cur_d   = first_idx;
          busy_d  = 1'b1;
          state_d = SEEK;
        end
      end
      SEEK: begin
        chan_d  = cur_q;
        disc_d  = '0;
        state_d = DISCARD;
      end
      DISCARD: begin
        if (adc_done) begin
          if (disc_q == DISC_W'(DISCARD_N - 1)) begin
            acc_d   = '0;
            smp_d   = '0;
            state_d = ACCUM;
          end else begin
            disc_d = disc_q + 1'b1;
          end
        end
      end
      ACCUM: begin
        if (adc_done) begin
          acc_d = acc_q + ACC_W'(adc_result);
          if (smp_q == SMP_W'((1 << AVG_LOG2) - 1)) begin
            state_d = STORE;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      STORE: begin
        bank_d[cur_q] = store_val;
        res_valid_d   = res_valid_q | (NUM_CH'(1) << cur_q);
        if (next_found) begin
          cur_d   = next_idx;
          state_d = SEEK;
        end else begin
          scan_done_d = 1'b1;
          // Continuous mode re-evaluates the live mask in this same cycle.
          if (cont && first_found) begin
            mask_d  = ch_mask;
            cur_d   = first_idx;
            state_d = SEEK;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any pass with no partial store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cur_q       <= '0;
      chan_q      <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      disc_q      <= '0;
      smp_q       <= '0;
      acc_q       <= '0;
      rd_data_q   <= '0;
      res_valid_q <= '0;
      for (int i = 0; i < BANK_N; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cur_q       <= cur_d;
      chan_q      <= chan_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      disc_q      <= disc_d;
      smp_q       <= smp_d;
      acc_q       <= acc_d;
      rd_data_q   <= rd_data_d;
      res_valid_q <= res_valid_d;
      for (int i = 0; i < BANK_N; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign chan      = chan_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;
  assign rd_data   = rd_data_q;
  assign res_valid = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_adc_scan_ctrl                                      |
// | Desc     : Directed self-checking bench for adc_scan_ctrl.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cont;
  logic        adc_done;
  logic [11:0] adc_result;

  // Main instance: 8 channels, 4-sample average, 1 discard.
  logic [7:0]  ch_mask;
  logic [2:0]  rd_ch;
  logic [2:0]  chan;
  logic        busy;
  logic        scan_done;
  logic [11:0] rd_data;
  logic [7:0]  res_valid;

  // Second instance: 4 channels, 2-sample average, 2 discards.
  logic [3:0]  ch_mask2;
  logic [2:0]  rd_ch2;
  logic [2:0]  chan2;
  logic        busy2;
  logic        scan_done2;
  logic [11:0] rd_data2;
  logic [3:0]  res_valid2;

  int n_chk = 0;
  int n_bad = 0;
  int n_sd  = 0;
  int n_busy = 0;
  int sd_base;
  int busy_base;

  always #5 clk = ~clk;

  adc_scan_ctrl #(.NUM_CH(8), .AVG_LOG2(2), .DISCARD_N(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cont       (cont),
    .ch_mask    (ch_mask),
    .adc_done   (adc_done),
    .adc_result (adc_result),
    .chan       (chan),
    .busy       (busy),
    .scan_done  (scan_done),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .res_valid  (res_valid)
  );

  adc_scan_ctrl #(.NUM_CH(4), .AVG_LOG2(1), .DISCARD_N(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cont       (cont),
    .ch_mask    (ch_mask2),
    .adc_done   (adc_done),
    .adc_result (adc_result),
    .chan       (chan2),
    .busy       (busy2),
    .scan_done  (scan_done2),
    .rd_ch      (rd_ch2),
    .rd_data    (rd_data2),
    .res_valid  (res_valid2)
  );

  // Count scan_done pulses and busy cycles of the main instance.
  always @(posedge clk) begin
    if (scan_done) n_sd <= n_sd + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One adc_done strobe followed by one idle cycle.
  task automatic strobe(input logic [11:0] val);
    adc_done   = 1'b1;
    adc_result = val;
    tick();
    adc_done   = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cont = 1'b0; adc_done = 1'b0; adc_result = '0;
    ch_mask = '0; rd_ch = '0; ch_mask2 = '0; rd_ch2 = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_chan",      32'(chan),      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);

    // Basic pass over channels 0 and 2
    sd_base = n_sd;
    ch_mask = 8'h05; rd_ch = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_rise", 32'(busy), 32'd1);
    tick();
    chk("t1_chan0", 32'(chan), 32'd0);
    strobe(12'd999);
    strobe(12'd100); strobe(12'd101); strobe(12'd102); strobe(12'd103);
    tick();
    chk("t1_chan2", 32'(chan), 32'd2);
    strobe(12'd7);
    for (int i = 0; i < 4; i++) strobe(12'd4000);
    chk("t1_scan_done", 32'(scan_done), 32'd1);
    chk("t1_busy_fall", 32'(busy),      32'd0);
    chk("t1_rd_old",    32'(rd_data),   32'd0);
    tick();
    chk("t1_rd_new",    32'(rd_data),   32'd4000);
    chk("t1_sd_once",   32'(scan_done), 32'd0);
    rd_ch = 3'd0;
    tick();
    chk("t1_bank0",     32'(rd_data),   32'd101);
    chk("t1_res_valid", 32'(res_valid), 32'h05);
    chk("t1_sd_count",  32'(n_sd - sd_base), 32'd1);

    // Empty mask never starts a pass
    sd_base = n_sd; busy_base = n_busy;
    ch_mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t2_busy_cnt", 32'(n_busy - busy_base), 32'd0);
    chk("t2_sd_cnt",   32'(n_sd - sd_base),     32'd0);
    chk("t2_chan",     32'(chan),               32'd2);

    // Continuous mode on channel 7, then drop cont mid-pass
    sd_base = n_sd;
    ch_mask = 8'h80; cont = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      tick();
      for (int s = 0; s < 5; s++) strobe(12'hABC);
      chk("t3_sd_pulse", 32'(scan_done), 32'd1);
      chk("t3_busy_hold", 32'(busy),     32'd1);
    end
    chk("t3_chan7", 32'(chan), 32'd7);
    tick();
    for (int s = 0; s < 3; s++) strobe(12'hABC);
    cont = 1'b0;
    for (int s = 0; s < 2; s++) strobe(12'hABC);
    chk("t3_last_sd",   32'(scan_done), 32'd1);
    chk("t3_last_busy", 32'(busy),      32'd0);
    tick(); tick(); tick();
    chk("t3_idle_busy", 32'(busy),      32'd0);
    chk("t3_sd_count",  32'(n_sd - sd_base), 32'd3);
    rd_ch = 3'd7;
    tick();
    chk("t3_bank7", 32'(rd_data), 32'hABC);

    // Mask change mid-pass only affects the next pass
    ch_mask = 8'h03; cont = 1'b1;
    tick();
    tick();
    chk("t4_chan0", 32'(chan), 32'd0);
    strobe(12'd999);
    strobe(12'd10); strobe(12'd20);
    ch_mask = 8'h10;
    strobe(12'd30); strobe(12'd41);
    tick();
    chk("t4_chan1", 32'(chan), 32'd1);
    strobe(12'd0);
    for (int s = 0; s < 4; s++) strobe(12'd4095);
    chk("t4_sd",   32'(scan_done), 32'd1);
    chk("t4_busy", 32'(busy),      32'd1);
    tick();
    chk("t4_chan4", 32'(chan), 32'd4);
    cont = 1'b0;
    strobe(12'd0);
    strobe(12'd1); strobe(12'd2); strobe(12'd3); strobe(12'd4);
    chk("t4_sd2",   32'(scan_done), 32'd1);
    chk("t4_busy2", 32'(busy),      32'd0);
    rd_ch = 3'd0; tick();
    chk("t4_bank0", 32'(rd_data), 32'd25);
    rd_ch = 3'd1; tick();
    chk("t4_bank1", 32'(rd_data), 32'd4095);
    rd_ch = 3'd4; tick();
    chk("t4_bank4", 32'(rd_data), 32'd2);
    chk("t4_res_valid", 32'(res_valid), 32'h97);

    // Reset during accumulation of channel 3
    ch_mask = 8'h08; rd_ch = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5_chan3", 32'(chan), 32'd3);
    strobe(12'd5);
    strobe(12'd100); strobe(12'd100);
    reset = 1'b1;
    tick();
    chk("t5_chan",      32'(chan),      32'd0);
    chk("t5_busy",      32'(busy),      32'd0);
    chk("t5_scan_done", 32'(scan_done), 32'd0);
    chk("t5_rd_data",   32'(rd_data),   32'd0);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    ch_mask = 8'h00; rd_ch = 3'd3;
    reset = 1'b0;
    strobe(12'd100); strobe(12'd100);
    chk("t5_bank3", 32'(rd_data), 32'd0);
    rd_ch = 3'd4; tick();
    chk("t5_bank4_cleared", 32'(rd_data), 32'd0);

    // Second instance: two discards, 2-sample average, out-of-range read
    ch_mask2 = 4'h8; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_busy", 32'(busy2), 32'd1);
    tick();
    chk("t6_chan3", 32'(chan2), 32'd3);
    strobe(12'd50); strobe(12'd60);
    strobe(12'd7);  strobe(12'd8);
    chk("t6_sd",    32'(scan_done2), 32'd1);
    chk("t6_busy0", 32'(busy2),      32'd0);
    rd_ch2 = 3'd3; tick();
    chk("t6_bank3", 32'(rd_data2), 32'd7);
    rd_ch2 = 3'd7; tick();
    chk("t6_rd_oob", 32'(rd_data2), 32'd0);
    chk("t6_res_valid", 32'(res_valid2), 32'h8);
    chk("t6_main_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Channel scan controller for the ADC path. It sequences the 3-bit `chan` select of the ADC serial interface across a programmable set of channels. It discards the stale conversions that follow each channel change, averages 2^AVG_LOG2 samples per channel and stores one averaged 12-bit result per channel in a register bank. The processor/game logic and the 7-segment display mux read the bank through a registered read port instead of driving `chan` directly.

## Interface
- NUM_CH, 8: number of channels, 1..8; channel indices 0..NUM_CH-1.
- AVG_LOG2, 2: log2 of the number of samples averaged per channel visit, 0..4.
- DISCARD_N, 2: conversions discarded after every `chan` change, 1..3. Covers the pipelined channel config and a `chan` change landing mid-frame.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse that begins a scan pass; ignored while busy.
- cont  in  1  level; while high, a finished pass immediately restarts.
- ch_mask  in  NUM_CH  enabled channels; latched at pass start.
- adc_done  in  1  1-cycle strobe in the clk domain; adc_result valid in that cycle.
- adc_result  in  12  conversion result from the ADC interface.
- chan  out  3  channel select to the ADC interface.
- busy  out  1  high from pass start until return to IDLE.
- scan_done  out  1  1-cycle pulse after the last enabled channel of a pass is stored.
- rd_ch  in  3  read index.
- rd_data  out  12  registered result for rd_ch.
- res_valid  out  NUM_CH  bit i set once channel i has been stored since reset.

## Operation
- States: IDLE, SEEK, DISCARD, ACCUM, STORE.
- IDLE:
  - On `start`, or on `cont` high: if ch_mask≠0, latch mask into mask_q, set cur=lowest set bit, go SEEK.
  - If ch_mask=0, stay IDLE with no busy and no scan_done.
- SEEK: one cycle; `chan`<=cur; discard counter<=0; go DISCARD.
- DISCARD: each adc_done increments the discard count. The DISCARD_N-th strobe moves to ACCUM with acc=0 and sample count=0. Results are ignored.
- ACCUM: each adc_done adds adc_result into acc. On the 2^AVG_LOG2-th strobe go STORE.
- STORE, one cycle:
  - bank[cur]<=acc>>AVG_LOG2 (truncating); res_valid[cur]<=1.
  - If a higher bit is set in mask_q: cur<=next set bit, go SEEK.
  - Otherwise pulse scan_done. If cont is high, re-latch ch_mask and restart: IDLE rules, same cycle decision. If cont is low, go IDLE.
- adc_done in SEEK, STORE or IDLE is ignored.
- ch_mask changes mid-pass take effect at the next pass start only.
- Dropping cont mid-pass completes the current pass, then IDLE.
- start while busy is ignored.
- Arithmetic:
  - acc width 12+AVG_LOG2; it cannot overflow.
  - Stored value = floor(sum/2^AVG_LOG2).
- Read port:
  - rd_data<=bank[rd_ch] each clk.
  - rd_ch≥NUM_CH returns 0.
  - A read of the channel being stored in the same cycle returns the old value; the new value appears one cycle later.

## Timing
- Reset values:
  - Outputs: chan=0, busy=0, scan_done=0, rd_data=0, res_valid=0.
  - Internal: bank all 0, state IDLE, cur=0, acc=0.
- Reset asserted mid-pass aborts immediately to the reset state. No partial store occurs.
- busy rises the cycle after start is sampled.
- chan updates the cycle after SEEK is entered.
- Per-channel visit: DISCARD_N+2^AVG_LOG2 adc_done strobes, plus 2 clk (SEEK, STORE).
- scan_done asserts the cycle after the final STORE. In single-shot mode busy falls that same cycle.
- rd_data latency: 1 clk.

## Structure
- Package adc_scan_pkg holds:
  - ADC_W=12, CH_W=3.
  - State enum scan_state_t {IDLE, SEEK, DISCARD, ACCUM, STORE}.
- Sub-module adc_ch_next: combinational find-first-set in mask above index cur. Outputs next index and `found`; with cur=-1 (separate `first` input) it returns the lowest set bit.
- Everything else lives in adc_scan_ctrl.

## Test plan
- AVG_LOG2=2, DISCARD_N=1, ch_mask=8'h05, start. Ch0: strobes 999, then 100,101,102,103. Ch2: strobes 7, then 4×4000.
  - bank[0]=101, bank[2]=4000, res_valid=8'h05.
  - chan sequence 0→2; one scan_done pulse; busy low afterwards.
- ch_mask=0, start → stays IDLE; busy and scan_done never assert; chan unchanged.
- cont=1, mask=8'h80, constant result 12'hABC → scan_done every DISCARD_N+4 strobes. Drop cont mid-pass → exactly one more scan_done, then IDLE.
- Change ch_mask from 8'h03 to 8'h10 during ACCUM of ch0 → pass still visits ch0, ch1. Next cont pass visits only ch4.
- Assert reset during ACCUM of ch3 → all outputs return to reset values next cycle; bank[3] stays 0; res_valid=0.
- Read rd_ch=2 in the STORE cycle of ch2 → old value that cycle, new value the following cycle. rd_ch=7 with NUM_CH=4 → 0.
